// File: rtl/mesi_line_array_pkg.sv
// MESI line-state, bus-op and controller-state types plus the snoop transition rule.
// Shared by the line array controller and its interface users.
package mesi_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        E = 2'b10,
        M = 2'b11
    } mesi_state_t;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_RDX  = 2'b01,
        BUS_UPGR = 2'b10
    } bus_op_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        BUS_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        mesi_state_t next;
        logic        flush;
        logic        err;
    } snoop_res_t;

    // An upgrade seen while we hold E or M means another agent believed it had S.
    function automatic snoop_res_t mesi_snoop_next(input mesi_state_t state, input logic [1:0] op);
        snoop_res_t r;
        r.next  = state;
        r.flush = 1'b0;
        r.err   = 1'b0;
        case (op)
            BUS_RD: begin
                if (state == M || state == E) r.next = S;
                r.flush = (state == M);
            end
            BUS_RDX: begin
                r.next  = I;
                r.flush = (state == M);
            end
            BUS_UPGR: begin
                r.next  = I;
                r.flush = (state == M);
                r.err   = (state == E) || (state == M);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mesi_line_array_if.sv
// Processor request, own bus transaction and snoop signals of the MESI line array.
// slave = the controller, master = the surrounding processor/bus environment.
interface mesi_line_array_if #(
    parameter int IDX_W = 3
) ();
    logic             cpu_req_valid;
    logic             cpu_req_write;
    logic [IDX_W-1:0] cpu_req_idx;
    logic             cpu_req_ready;
    logic             cpu_resp_valid;
    logic             bus_req_valid;
    logic [1:0]       bus_req_op;
    logic [IDX_W-1:0] bus_req_idx;
    logic             bus_grant;
    logic             bus_shared;
    logic             snoop_valid;
    logic [1:0]       snoop_op;
    logic [IDX_W-1:0] snoop_idx;
    logic             snoop_hit;
    logic             snoop_flush;
    logic             protocol_err;

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_idx, bus_grant, bus_shared,
               snoop_valid, snoop_op, snoop_idx,
        output cpu_req_ready, cpu_resp_valid, bus_req_valid, bus_req_op, bus_req_idx,
               snoop_hit, snoop_flush, protocol_err
    );

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_idx, bus_grant, bus_shared,
               snoop_valid, snoop_op, snoop_idx,
        input  cpu_req_ready, cpu_resp_valid, bus_req_valid, bus_req_op, bus_req_idx,
               snoop_hit, snoop_flush, protocol_err
    );
endinterface

// File: rtl/mesi_line_array.sv
// MESI coherence controller for NUM_LINES direct-indexed lines with an own-bus-request FSM.
// Latency: hits and grants respond next cycle, snoop results next cycle.
// Backpressure: cpu_req_ready drops during snoops and while a bus transaction is outstanding.
module mesi_line_array
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    mesi_line_array_if.slave ifc,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [1:0]       dbg_state
);

    localparam logic [0:0] ST_IDLE     = IDLE;
    localparam logic [0:0] ST_BUS_WAIT = BUS_WAIT;

    mesi_state_t      lines [NUM_LINES];
    logic [0:0]       ctrl;
    logic             req_vld;
    bus_op_t          req_op;
    logic [IDX_W-1:0] req_idx;
    logic             resp_vld;
    logic             hit_q;
    logic             flush_q;
    logic             err_q;

    mesi_state_t cpu_line;
    mesi_state_t snoop_line;
    mesi_state_t grant_state;
    snoop_res_t  snp;
    logic        accept;
    logic        grant;
    logic        overlap;
    logic        snoop_apply;

    always_comb begin
        cpu_line    = lines[ifc.cpu_req_idx];
        snoop_line  = lines[ifc.snoop_idx];
        snp         = mesi_snoop_next(snoop_line, ifc.snoop_op);
        accept      = ifc.cpu_req_valid && (ctrl == ST_IDLE) && !ifc.snoop_valid;
        grant       = (ctrl == ST_BUS_WAIT) && ifc.bus_grant;
        // A snoop on our own line in the grant cycle cannot be ordered; the grant wins.
        overlap     = grant && ifc.snoop_valid && (ifc.snoop_idx == req_idx);
        snoop_apply = ifc.snoop_valid && !overlap;
        grant_state = (req_op == BUS_RD) ? (ifc.bus_shared ? S : E) : M;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_LINES; k++) lines[k] <= I;
            ctrl     <= ST_IDLE;
            req_vld  <= 1'b0;
            req_op   <= BUS_RD;
            req_idx  <= '0;
            resp_vld <= 1'b0;
            hit_q    <= 1'b0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            resp_vld <= 1'b0;
            hit_q    <= snoop_apply && (snoop_line != I);
            flush_q  <= snoop_apply && snp.flush;
            if (overlap || (snoop_apply && snp.err)) err_q <= 1'b1;
            if (snoop_apply) lines[ifc.snoop_idx] <= snp.next;

            case (ctrl)
                ST_IDLE: begin
                    if (accept) begin
                        if (cpu_line != I && !(ifc.cpu_req_write && cpu_line == S)) begin
                            if (ifc.cpu_req_write) lines[ifc.cpu_req_idx] <= M;
                            resp_vld <= 1'b1;
                        end else begin
                            req_vld <= 1'b1;
                            req_idx <= ifc.cpu_req_idx;
                            req_op  <= !ifc.cpu_req_write ? BUS_RD :
                                       (cpu_line == S) ? BUS_UPGR : BUS_RDX;
                            ctrl    <= ST_BUS_WAIT;
                        end
                    end
                end
                default: begin
                    if (grant) begin
                        lines[req_idx] <= grant_state;
                        resp_vld       <= 1'b1;
                        req_vld        <= 1'b0;
                        ctrl           <= ST_IDLE;
                    end else if (snoop_apply && ifc.snoop_idx == req_idx &&
                                 req_op == BUS_UPGR && snp.next == I) begin
                        // Our S copy was invalidated, so the upgrade must now fetch data.
                        req_op <= BUS_RDX;
                    end
                end
            endcase
        end
    end

    assign ifc.cpu_req_ready  = (ctrl == ST_IDLE) && !ifc.snoop_valid;
    assign ifc.cpu_resp_valid = resp_vld;
    assign ifc.bus_req_valid  = req_vld;
    assign ifc.bus_req_op     = req_op;
    assign ifc.bus_req_idx    = req_idx;
    assign ifc.snoop_hit      = hit_q;
    assign ifc.snoop_flush    = flush_q;
    assign ifc.protocol_err   = err_q;
    assign dbg_state          = lines[dbg_idx];

endmodule

// File: tb/tb_mesi_line_array.sv
// Directed and randomized bench for mesi_line_array: a per-cycle driver feeds a rule-level
// model that queues expectations; an independent negedge monitor pops and compares them.
module tb_mesi_line_array;

    localparam logic [1:0] LI = 2'b00, LS = 2'b01, LE = 2'b10, LM = 2'b11;
    localparam logic [1:0] OP_RD = 2'b00, OP_RDX = 2'b01, OP_UPGR = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_idx = '0;
    logic [1:0] dbg_state;

    mesi_line_array_if #(.IDX_W(3)) bif ();

    mesi_line_array #(.NUM_LINES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ifc       (bif.slave),
        .dbg_idx   (dbg_idx),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       rdy;
        logic       bv;
        logic [1:0] op;
        logic [2:0] idx;
        logic       hit;
        logic       flush;
        logic       err;
        logic [2:0] di;
        logic [1:0] dst;
    } exp_t;

    exp_t cyc_q[$];
    int   resp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Reference model: line states and the single outstanding bus request.
    logic [1:0] m_line [8];
    logic       m_busy;
    logic [1:0] m_op;
    logic [2:0] m_idx;
    logic       m_hit, m_flush, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_line[k] = LI;
        m_busy  = 1'b0;
        m_op    = OP_RD;
        m_idx   = '0;
        m_hit   = 1'b0;
        m_flush = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive inputs, queue what the DUT should show now, advance the model.
    task automatic step(input logic rst, input logic cv, input logic cw, input logic [2:0] ci,
                        input logic g, input logic sh, input logic sv, input logic [1:0] so,
                        input logic [2:0] si, input logic [2:0] di, output logic acc);
        exp_t       e;
        logic       gnt, ovl, was_busy;
        logic [1:0] old, nxt;
        reset             = rst;
        bif.cpu_req_valid = cv;
        bif.cpu_req_write = cw;
        bif.cpu_req_idx   = ci;
        bif.bus_grant     = g;
        bif.bus_shared    = sh;
        bif.snoop_valid   = sv;
        bif.snoop_op      = so;
        bif.snoop_idx     = si;

        e.cyc = cyc_n;    e.rdy = !m_busy && !sv;
        e.bv  = m_busy;   e.op  = m_op;    e.idx = m_idx;
        e.hit = m_hit;    e.flush = m_flush; e.err = m_err;
        e.di  = di;       e.dst = m_line[di];
        cyc_q.push_back(e);

        acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            was_busy = m_busy;
            gnt      = m_busy && g;
            ovl      = gnt && sv && (si == m_idx);
            m_hit    = 1'b0;
            m_flush  = 1'b0;
            if (ovl) m_err = 1'b1;
            if (sv && !ovl) begin
                old     = m_line[si];
                nxt     = old;
                m_hit   = (old != LI);
                case (so)
                    OP_RD:   begin if (old == LM || old == LE) nxt = LS; m_flush = (old == LM); end
                    OP_RDX:  begin nxt = LI; m_flush = (old == LM); end
                    OP_UPGR: begin nxt = LI; m_flush = (old == LM); if (old == LE || old == LM) m_err = 1'b1; end
                    default: m_err = 1'b1;
                endcase
                m_line[si] = nxt;
                if (m_busy && !gnt && si == m_idx && m_op == OP_UPGR && nxt == LI) m_op = OP_RDX;
            end
            if (gnt) begin
                m_line[m_idx] = (m_op == OP_RD) ? (sh ? LS : LE) : LM;
                m_busy = 1'b0;
                resp_q.push_back(cyc_n + 1);
            end
            if (cv && !was_busy && !sv) begin
                acc = 1'b1;
                old = m_line[ci];
                if (!cw && old != LI) begin
                    resp_q.push_back(cyc_n + 1);
                end else if (cw && (old == LE || old == LM)) begin
                    m_line[ci] = LM;
                    resp_q.push_back(cyc_n + 1);
                end else begin
                    m_busy = 1'b1;
                    m_idx  = ci;
                    m_op   = !cw ? OP_RD : ((old == LS) ? OP_UPGR : OP_RDX);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input logic [2:0] di);
        logic a;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, di, a);
    endtask

    task automatic req(input logic w, input logic [2:0] idx);
        logic a;
        step(1'b0, 1'b1, w, idx, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, idx, a);
    endtask

    task automatic gnt(input logic sh, input logic [2:0] di);
        logic a;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, sh, 1'b0, 2'b00, 3'd0, di, a);
    endtask

    task automatic snp(input logic [1:0] op, input logic [2:0] idx);
        logic a;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, op, idx, idx, a);
    endtask

    // Monitor: one expectation per cycle, plus a response-timing queue popped on each pulse.
    always @(negedge clk) begin
        exp_t e;
        int   want;
        if (cyc_q.size() > 0) begin
            e       = cyc_q.pop_front();
            dbg_idx = e.di;
            #1;
            chk("cpu_req_ready", int'(bif.cpu_req_ready), int'(e.rdy));
            chk("bus_req_valid", int'(bif.bus_req_valid), int'(e.bv));
            if (e.bv) begin
                chk("bus_req_op", int'(bif.bus_req_op), int'(e.op));
                chk("bus_req_idx", int'(bif.bus_req_idx), int'(e.idx));
            end
            chk("snoop_hit", int'(bif.snoop_hit), int'(e.hit));
            chk("snoop_flush", int'(bif.snoop_flush), int'(e.flush));
            chk("protocol_err", int'(bif.protocol_err), int'(e.err));
            chk("dbg_state", int'(dbg_state), int'(e.dst));
            if (bif.cpu_resp_valid) begin
                want = (resp_q.size() > 0) ? resp_q.pop_front() : -1;
                chk("cpu_resp_cycle", e.cyc, want);
            end
        end
    end

    initial begin
        logic       r_cv, r_cw, acc, g, sv, rst;
        logic [2:0] r_ci;
        logic [1:0] so;

        reset = 1'b1;
        bif.cpu_req_valid = 1'b0; bif.cpu_req_write = 1'b0; bif.cpu_req_idx = '0;
        bif.bus_grant = 1'b0;     bif.bus_shared = 1'b0;
        bif.snoop_valid = 1'b0;   bif.snoop_op = 2'b00;     bif.snoop_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int k = 0; k < 8; k++) idle(3'(k));

        // Read miss on 3, exclusive fill, then silent write upgrade to M.
        req(1'b0, 3'd3); idle(3'd3); gnt(1'b0, 3'd3); idle(3'd3);
        req(1'b1, 3'd3); idle(3'd3); idle(3'd3);

        // Shared fill on 5, upgrade converted to RDX by a snoop before grant.
        req(1'b0, 3'd5); idle(3'd5); gnt(1'b1, 3'd5); idle(3'd5);
        req(1'b1, 3'd5); idle(3'd5); snp(OP_RDX, 3'd5); idle(3'd5);
        gnt(1'b0, 3'd5); idle(3'd5);

        // Modified line 2 snooped by a read (flush, S) and then a read-exclusive.
        req(1'b1, 3'd2); idle(3'd2); gnt(1'b0, 3'd2); idle(3'd2);
        snp(OP_RD, 3'd2); idle(3'd2); snp(OP_RDX, 3'd2); idle(3'd2);

        // Held request blocked by three snoop cycles, accepted once the snoop drops.
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, OP_RD, 3'd7, 3'd3, acc);
        step(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, OP_RD, 3'd0, 3'd3, acc);
        idle(3'd3); idle(3'd3);

        // Reset while a bus request is outstanding.
        req(1'b0, 3'd6); idle(3'd6);
        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 3'd6, acc);
        for (int k = 0; k < 8; k++) idle(3'(k));

        // Upgrade snooped on a Modified line: invalidate, flush, sticky error.
        req(1'b1, 3'd1); idle(3'd1); gnt(1'b0, 3'd1); idle(3'd1);
        snp(OP_UPGR, 3'd1); idle(3'd1); idle(3'd1); idle(3'd4);

        // Randomized traffic.
        r_cv = 1'b0; r_cw = 1'b0; r_ci = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!r_cv && $urandom_range(2) == 0) begin
                r_cv = 1'b1;
                r_cw = 1'($urandom_range(1));
                r_ci = 3'($urandom_range(7));
            end
            sv  = ($urandom_range(3) == 0);
            so  = ($urandom_range(31) == 0) ? 2'b11 : 2'($urandom_range(2));
            rst = ($urandom_range(299) == 0);
            g   = m_busy && ($urandom_range(2) == 0);
            step(rst, r_cv, r_cw, r_ci, g, 1'($urandom_range(1)), sv, so,
                 3'($urandom_range(7)), 3'($urandom_range(7)), acc);
            if (acc) r_cv = 1'b0;
        end

        for (int k = 0; k < 4; k++) idle(3'(k));
        chk("resp_drain", resp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
